// File: rtl/tri_upper_matmul_3x3.sv
// Sequential 3x3 upper-triangular Q4.12 matrix product C = A x B using one shared MAC,
// with a saturating per-element finish and an identity-within-tolerance flag.
module tri_upper_matmul_3x3 #(
    parameter int WORD_LENGTH     = 16,
    parameter int FRACTION_LENGTH = 12,
    parameter int ACC_W           = 34,
    parameter int TOL             = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid,
    input  logic [WORD_LENGTH-1:0] a11,
    input  logic [WORD_LENGTH-1:0] a12,
    input  logic [WORD_LENGTH-1:0] a13,
    input  logic [WORD_LENGTH-1:0] a22,
    input  logic [WORD_LENGTH-1:0] a23,
    input  logic [WORD_LENGTH-1:0] a33,
    input  logic [WORD_LENGTH-1:0] b11,
    input  logic [WORD_LENGTH-1:0] b12,
    input  logic [WORD_LENGTH-1:0] b13,
    input  logic [WORD_LENGTH-1:0] b22,
    input  logic [WORD_LENGTH-1:0] b23,
    input  logic [WORD_LENGTH-1:0] b33,
    output logic [WORD_LENGTH-1:0] c11,
    output logic [WORD_LENGTH-1:0] c12,
    output logic [WORD_LENGTH-1:0] c13,
    output logic [WORD_LENGTH-1:0] c22,
    output logic [WORD_LENGTH-1:0] c23,
    output logic [WORD_LENGTH-1:0] c33,
    output logic                   busy,
    output logic                   done,
    output logic                   ovf,
    output logic                   ident_ok
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam logic [3:0] LAST_TERM = 4'd9;
    localparam int         PROD_W    = 2 * WORD_LENGTH;

    localparam logic signed [WORD_LENGTH:0] ONE_EXT = (WORD_LENGTH + 1)'(1 << FRACTION_LENGTH);

    logic [1:0]                    state_q, state_d;
    logic [3:0]                    idx_q, idx_d;
    logic signed [ACC_W-1:0]       acc_q, acc_d;
    logic [5:0][WORD_LENGTH-1:0]   a_q, a_d;
    logic [5:0][WORD_LENGTH-1:0]   b_q, b_d;
    logic [5:0][WORD_LENGTH-1:0]   res_q, res_d;
    logic [5:0][WORD_LENGTH-1:0]   c_q, c_d;
    logic                          pend_ovf_q, pend_ovf_d;
    logic                          ovf_q, ovf_d;
    logic                          ident_q, ident_d;
    logic                          done_q, done_d;

    logic [2:0]                    sel_a, sel_b, dest;
    logic                          term_last;
    logic [WORD_LENGTH-1:0]        op_a, op_b;
    logic signed [PROD_W-1:0]      op_a_ext, op_b_ext, prod;
    logic signed [ACC_W-1:0]       prod_ext, sum, shifted;
    logic                          elem_ovf;
    logic [WORD_LENGTH-1:0]        sat_val;
    logic signed [WORD_LENGTH:0]   d11, d12, d13, d22, d23, d33;
    logic                          ident_calc;

    function automatic logic within_tol(input logic signed [WORD_LENGTH:0] diff);
        logic signed [WORD_LENGTH:0] mag;
        mag = diff[WORD_LENGTH] ? -diff : diff;
        return mag <= (WORD_LENGTH + 1)'(TOL);
    endfunction

    // Operand/destination slot order is 0=x11 1=x12 2=x13 3=x22 4=x23 5=x33.
    always_comb begin
        sel_a     = 3'd0;
        sel_b     = 3'd0;
        dest      = 3'd0;
        term_last = 1'b0;
        case (idx_q)
            4'd0: begin sel_a = 3'd0; sel_b = 3'd0; term_last = 1'b1; dest = 3'd0; end
            4'd1: begin sel_a = 3'd0; sel_b = 3'd1; end
            4'd2: begin sel_a = 3'd1; sel_b = 3'd3; term_last = 1'b1; dest = 3'd1; end
            4'd3: begin sel_a = 3'd0; sel_b = 3'd2; end
            4'd4: begin sel_a = 3'd1; sel_b = 3'd4; end
            4'd5: begin sel_a = 3'd2; sel_b = 3'd5; term_last = 1'b1; dest = 3'd2; end
            4'd6: begin sel_a = 3'd3; sel_b = 3'd3; term_last = 1'b1; dest = 3'd3; end
            4'd7: begin sel_a = 3'd3; sel_b = 3'd4; end
            4'd8: begin sel_a = 3'd4; sel_b = 3'd5; term_last = 1'b1; dest = 3'd4; end
            default: begin sel_a = 3'd5; sel_b = 3'd5; term_last = 1'b1; dest = 3'd5; end
        endcase
    end

    always_comb begin
        op_a     = a_q[sel_a];
        op_b     = b_q[sel_b];
        op_a_ext = {{WORD_LENGTH{op_a[WORD_LENGTH-1]}}, op_a};
        op_b_ext = {{WORD_LENGTH{op_b[WORD_LENGTH-1]}}, op_b};
        prod     = op_a_ext * op_b_ext;
        prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        sum      = acc_q + prod_ext;
        shifted  = sum >>> FRACTION_LENGTH;
        // The element fits only if every bit above the result's sign bit matches it.
        elem_ovf = !((&shifted[ACC_W-1:WORD_LENGTH-1]) || !(|shifted[ACC_W-1:WORD_LENGTH-1]));
        if (elem_ovf) begin
            sat_val = shifted[ACC_W-1] ? {1'b1, {(WORD_LENGTH - 1){1'b0}}}
                                       : {1'b0, {(WORD_LENGTH - 1){1'b1}}};
        end else begin
            sat_val = shifted[WORD_LENGTH-1:0];
        end
    end

    always_comb begin
        d11 = signed'({res_q[0][WORD_LENGTH-1], res_q[0]}) - ONE_EXT;
        d12 = signed'({res_q[1][WORD_LENGTH-1], res_q[1]});
        d13 = signed'({res_q[2][WORD_LENGTH-1], res_q[2]});
        d22 = signed'({res_q[3][WORD_LENGTH-1], res_q[3]}) - ONE_EXT;
        d23 = signed'({res_q[4][WORD_LENGTH-1], res_q[4]});
        d33 = signed'({res_q[5][WORD_LENGTH-1], res_q[5]}) - ONE_EXT;
        ident_calc = within_tol(d11) && within_tol(d12) && within_tol(d13) &&
                     within_tol(d22) && within_tol(d23) && within_tol(d33);
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        c_d        = c_q;
        pend_ovf_d = pend_ovf_q;
        ovf_d      = ovf_q;
        ident_d    = ident_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid) begin
                    a_d        = {a33, a23, a22, a13, a12, a11};
                    b_d        = {b33, b23, b22, b13, b12, b11};
                    acc_d      = '0;
                    idx_d      = 4'd0;
                    pend_ovf_d = 1'b0;
                    state_d    = S_MAC;
                end
            end
            S_MAC: begin
                if (term_last) begin
                    res_d[dest] = sat_val;
                    pend_ovf_d  = pend_ovf_q | elem_ovf;
                    acc_d       = '0;
                end else begin
                    acc_d = sum;
                end
                if (idx_q == LAST_TERM) begin
                    idx_d   = 4'd0;
                    state_d = S_OUT;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            S_OUT: begin
                c_d     = res_q;
                ovf_d   = pend_ovf_q;
                ident_d = ident_calc;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            acc_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            c_q        <= '0;
            pend_ovf_q <= 1'b0;
            ovf_q      <= 1'b0;
            ident_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            c_q        <= c_d;
            pend_ovf_q <= pend_ovf_d;
            ovf_q      <= ovf_d;
            ident_q    <= ident_d;
            done_q     <= done_d;
        end
    end

    assign c11      = c_q[0];
    assign c12      = c_q[1];
    assign c13      = c_q[2];
    assign c22      = c_q[3];
    assign c23      = c_q[4];
    assign c33      = c_q[5];
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign ovf      = ovf_q;
    assign ident_ok = ident_q;

endmodule

// File: tb/tb_tri_upper_matmul_3x3.sv
// Directed self-checking bench for tri_upper_matmul_3x3 with hand-computed Q4.12 results.
module tb_tri_upper_matmul_3x3;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [15:0] a11, a12, a13, a22, a23, a33;
    logic [15:0] b11, b12, b13, b22, b23, b33;
    logic [15:0] c11, c12, c13, c22, c23, c33;
    logic        busy, done, ovf, ident_ok;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    tri_upper_matmul_3x3 dut (
        .clk(clk), .rst(rst), .valid(valid),
        .a11(a11), .a12(a12), .a13(a13), .a22(a22), .a23(a23), .a33(a33),
        .b11(b11), .b12(b12), .b13(b13), .b22(b22), .b23(b23), .b33(b33),
        .c11(c11), .c12(c12), .c13(c13), .c22(c22), .c23(c23), .c33(c33),
        .busy(busy), .done(done), .ovf(ovf), .ident_ok(ident_ok)
    );

    task automatic drive(input logic [15:0] x11, x12, x13, x22, x23, x33,
                         input logic [15:0] y11, y12, y13, y22, y23, y33);
        a11 = x11; a12 = x12; a13 = x13; a22 = x22; a23 = x23; a33 = x33;
        b11 = y11; b12 = y12; b13 = y13; b22 = y22; b23 = y23; b33 = y33;
    endtask

    task automatic drive_identity();
        drive(16'h1000, 16'h0, 16'h0, 16'h1000, 16'h0, 16'h1000,
              16'h1000, 16'h0, 16'h0, 16'h1000, 16'h0, 16'h1000);
    endtask

    task automatic scramble();
        drive(16'hA5A5, 16'h5A5A, 16'h1234, 16'h4321, 16'h7777, 16'h8888,
              16'hA5A5, 16'h5A5A, 16'h1234, 16'h4321, 16'h7777, 16'h8888);
    endtask

    // Starts an operation with the inputs already driven; lat = edges from E0 to done (0 on timeout).
    task automatic run_op(output int lat);
        @(negedge clk);
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        scramble();
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        valid = 1'b0;
        drive_identity();
        #2 rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if ({c11, c12, c13, c22, c23, c33} !== 96'h0)
            $display("[TB] FAIL reset_c: got %h expected 0", {c11, c12, c13, c22, c23, c33});
        else passed++;
        checks++;
        if ({busy, done, ovf, ident_ok} !== 4'b0000)
            $display("[TB] FAIL reset_flags: got %b expected 0000", {busy, done, ovf, ident_ok});
        else passed++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_identity();
        int lat;
        drive_identity();
        run_op(lat);
        checks++;
        if (lat !== 11) $display("[TB] FAIL identity_latency: got %0d expected 11", lat);
        else passed++;
        checks++;
        if ({c11, c12, c13, c22, c23, c33} !== {16'h1000, 16'h0, 16'h0, 16'h1000, 16'h0, 16'h1000})
            $display("[TB] FAIL identity_c: got %h expected identity", {c11, c12, c13, c22, c23, c33});
        else passed++;
        checks++;
        if ({ident_ok, ovf, busy} !== 3'b100)
            $display("[TB] FAIL identity_flags: got ident/ovf/busy=%b expected 100", {ident_ok, ovf, busy});
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if ({done, c11, c22, ident_ok} !== {1'b0, 16'h1000, 16'h1000, 1'b1})
            $display("[TB] FAIL identity_hold: got done=%b c11=%h c22=%h ident=%b expected 0/1000/1000/1",
                     done, c11, c22, ident_ok);
        else passed++;
    endtask

    task automatic test_inverse_pair();
        int lat;
        drive(16'h1000, 16'h2000, 16'h3000, 16'h1000, 16'h4000, 16'h1000,
              16'h1000, 16'hE000, 16'h5000, 16'h1000, 16'hC000, 16'h1000);
        run_op(lat);
        checks++;
        if ({c11, c12, c13, c22, c23, c33} !== {16'h1000, 16'h0, 16'h0, 16'h1000, 16'h0, 16'h1000})
            $display("[TB] FAIL inverse_c: got %h expected identity", {c11, c12, c13, c22, c23, c33});
        else passed++;
        checks++;
        if ({lat[4:0], ident_ok, ovf} !== {5'd11, 1'b1, 1'b0})
            $display("[TB] FAIL inverse_flags: got lat=%0d ident=%b ovf=%b expected 11/1/0", lat, ident_ok, ovf);
        else passed++;
    endtask

    task automatic test_saturation();
        int lat;
        drive(16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
              16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        run_op(lat);
        checks++;
        if ({c11, ovf, ident_ok} !== {16'h7FFF, 1'b1, 1'b0})
            $display("[TB] FAIL sat_pos: got c11=%h ovf=%b ident=%b expected 7fff/1/0", c11, ovf, ident_ok);
        else passed++;
        drive(16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
              16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        run_op(lat);
        checks++;
        if ({c11, c22, ovf} !== {16'h8000, 16'h0, 1'b1})
            $display("[TB] FAIL sat_neg: got c11=%h c22=%h ovf=%b expected 8000/0000/1", c11, c22, ovf);
        else passed++;
        drive_identity();
        run_op(lat);
        checks++;
        if ({c11, ovf, ident_ok} !== {16'h1000, 1'b0, 1'b1})
            $display("[TB] FAIL sat_clear: got c11=%h ovf=%b ident=%b expected 1000/0/1", c11, ovf, ident_ok);
        else passed++;
    endtask

    task automatic test_truncation();
        int lat;
        drive(16'hFFFF, 16'h0, 16'h0, 16'h0001, 16'h0, 16'h0,
              16'h0800, 16'h0, 16'h0, 16'h0800, 16'h0, 16'h0);
        run_op(lat);
        checks++;
        if (c11 !== 16'hFFFF) $display("[TB] FAIL trunc_neg: got %h expected ffff", c11);
        else passed++;
        checks++;
        if ({c22, c12, c33, ovf} !== {16'h0, 16'h0, 16'h0, 1'b0})
            $display("[TB] FAIL trunc_pos: got c22=%h c12=%h c33=%h ovf=%b expected 0/0/0/0", c22, c12, c33, ovf);
        else passed++;
    endtask

    task automatic test_tolerance();
        int lat;
        drive(16'h1008, 16'h0, 16'h0, 16'h1000, 16'h0, 16'h1000,
              16'h1000, 16'h0, 16'h0, 16'h1000, 16'h0, 16'h1000);
        run_op(lat);
        checks++;
        if ({c11, ident_ok} !== {16'h1008, 1'b1})
            $display("[TB] FAIL tol_diag_in: got c11=%h ident=%b expected 1008/1", c11, ident_ok);
        else passed++;
        a11 = 16'h1009;
        drive(16'h1009, 16'h0, 16'h0, 16'h1000, 16'h0, 16'h1000,
              16'h1000, 16'h0, 16'h0, 16'h1000, 16'h0, 16'h1000);
        run_op(lat);
        checks++;
        if ({c11, ident_ok} !== {16'h1009, 1'b0})
            $display("[TB] FAIL tol_diag_out: got c11=%h ident=%b expected 1009/0", c11, ident_ok);
        else passed++;
        drive(16'h1000, 16'hFFF8, 16'h0, 16'h1000, 16'h0, 16'h1000,
              16'h1000, 16'h0, 16'h0, 16'h1000, 16'h0, 16'h1000);
        run_op(lat);
        checks++;
        if ({c12, ident_ok} !== {16'hFFF8, 1'b1})
            $display("[TB] FAIL tol_off_in: got c12=%h ident=%b expected fff8/1", c12, ident_ok);
        else passed++;
        drive(16'h1000, 16'hFFF7, 16'h0, 16'h1000, 16'h0, 16'h1000,
              16'h1000, 16'h0, 16'h0, 16'h1000, 16'h0, 16'h1000);
        run_op(lat);
        checks++;
        if ({c12, ident_ok} !== {16'hFFF7, 1'b0})
            $display("[TB] FAIL tol_off_out: got c12=%h ident=%b expected fff7/0", c12, ident_ok);
        else passed++;
    endtask

    task automatic test_busy();
        int bad_edge = -1;
        int extra_done = 0;
        int extra_busy = 0;
        drive_identity();
        @(negedge clk);
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        if (busy !== 1'b1) bad_edge = 0;
        for (int e = 1; e <= 11; e++) begin
            if (e == 3) begin
                valid = 1'b1;
                drive(16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                      16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
            end
            @(posedge clk);
            #1;
            if (e == 3) valid = 1'b0;
            if (e <= 10 && {busy, done} !== 2'b10 && bad_edge < 0) bad_edge = e;
            if (e == 11 && {busy, done} !== 2'b01 && bad_edge < 0) bad_edge = e;
        end
        checks++;
        if (bad_edge !== -1) $display("[TB] FAIL busy_window: got bad busy/done after edge %0d expected none", bad_edge);
        else passed++;
        checks++;
        if ({c11, c22, ovf, ident_ok} !== {16'h1000, 16'h1000, 1'b0, 1'b1})
            $display("[TB] FAIL busy_result: got c11=%h c22=%h ovf=%b ident=%b expected 1000/1000/0/1",
                     c11, c22, ovf, ident_ok);
        else passed++;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
            if (busy) extra_busy++;
        end
        checks++;
        if ({extra_done, extra_busy} !== {32'd0, 32'd0})
            $display("[TB] FAIL busy_ignored: got dones=%0d busy_cycles=%0d expected 0/0", extra_done, extra_busy);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int n_done = 0;
        int first_at = 0;
        int second_at = 0;
        drive_identity();
        @(negedge clk);
        valid = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n_done++;
                if (n_done == 1) first_at = k;
                if (n_done == 2) begin
                    second_at = k;
                    valid = 1'b0;
                end
            end
        end
        valid = 1'b0;
        checks++;
        if ({first_at, second_at, n_done} !== {32'd12, 32'd24, 32'd2})
            $display("[TB] FAIL back_to_back: got done at %0d,%0d count %0d expected 12,24 count 2",
                     first_at, second_at, n_done);
        else passed++;
    endtask

    task automatic test_reset_mid_op();
        int lat;
        int seen_done = 0;
        drive(16'h1000, 16'h2000, 16'h3000, 16'h1000, 16'h4000, 16'h1000,
              16'h1000, 16'hE000, 16'h5000, 16'h1000, 16'hC000, 16'h1000);
        @(negedge clk);
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({c11, c12, c13, c22, c23, c33} !== 96'h0)
            $display("[TB] FAIL midrst_c: got %h expected 0", {c11, c12, c13, c22, c23, c33});
        else passed++;
        checks++;
        if ({busy, done, ovf, ident_ok} !== 4'b0000)
            $display("[TB] FAIL midrst_flags: got %b expected 0000", {busy, done, ovf, ident_ok});
        else passed++;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        checks++;
        if (seen_done !== 0) $display("[TB] FAIL midrst_no_done: got %0d dones expected 0", seen_done);
        else passed++;
        drive_identity();
        run_op(lat);
        checks++;
        if ({lat[4:0], c11, c33, ident_ok} !== {5'd11, 16'h1000, 16'h1000, 1'b1})
            $display("[TB] FAIL midrst_recover: got lat=%0d c11=%h c33=%h ident=%b expected 11/1000/1000/1",
                     lat, c11, c33, ident_ok);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_inverse_pair();
        test_saturation();
        test_truncation();
        test_tolerance();
        test_busy();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
